tft_bus_arbiter: RTL
====================

Name: tft_bus_arbiter

Overview:
- Owns the 16-bit parallel TFT write bus (RD/WR/RS/DATA) and shares it between two requesters.
  - Pixel stream port: real-time framebuffer pixels.
  - Command port: init sequencer or CPU register writes such as window set, scroll and 0x2C.
- Generates WR strobes with parameterised low/high widths.
- Keeps multi-word command transactions atomic.
- Bounds pixel priority so that commands cannot starve.
- Sits between the pixel/command producers and the TFT pins.

Parameters:
- WR_LOW_CYCLES, 1, clk cycles WR is held low per word (>=1).
- WR_HIGH_CYCLES, 1, minimum clk cycles WR is high between words (>=1).
- MAX_PIX_BURST, 64, consecutive pixel grants after which a pending command wins the next slot (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pix_valid  in  1  pixel word offered
- pix_rs  in  1  RS level for the pixel word (normally 1)
- pix_data  in  16  pixel word
- pix_ready  out  1  pixel word accepted this cycle when pix_valid also high
- cmd_valid  in  1  command word offered
- cmd_rs  in  1  RS level (0 = command, 1 = parameter)
- cmd_data  in  16  command word
- cmd_last  in  1  last word of this command transaction
- cmd_ready  out  1  command word accepted this cycle when cmd_valid also high
- screenRD  out  1  constant 1
- screenWR  out  1  write strobe, active-low
- screenRS  out  1  register select
- screenData  out  16  bus data
- busy  out  1  high whenever state != IDLE
- cmd_locked  out  1  command transaction in progress

Behaviour:
- Reset values (immediate on rst, asynchronous): screenWR=1, screenRS=1, screenData=0, state=IDLE, lock=0, burst count=0, all counters 0. screenRD is always 1.
- States:
  - IDLE: WR high; arbitration and accept happen here.
  - LOW: WR low for WR_LOW_CYCLES cycles.
  - HIGH: WR high for WR_HIGH_CYCLES-1 cycles; skipped when WR_HIGH_CYCLES=1.
  - Transitions: IDLE -> LOW on accept. LOW -> HIGH, or -> IDLE if WR_HIGH_CYCLES=1. HIGH -> IDLE.
- Ready signals: combinational; only ever high in IDLE and never both high. A transfer is valid&ready at the rising edge.
- On accept, at that edge: screenRS/screenData load the winner's rs/data, screenWR goes 0, state goes to LOW. Data and RS stay stable until the next accept.
- Word period is WR_LOW_CYCLES + WR_HIGH_CYCLES cycles. With defaults: WR low 1 cycle, high 1 cycle, one word every 2 clocks.
- Arbitration in IDLE, first match wins:
  1. lock=1: only cmd_ready may assert (= cmd_valid); pixels wait.
  2. cmd_valid and (pix_valid=0 or burst>=MAX_PIX_BURST): grant cmd.
  3. pix_valid: grant pix.
  4. Otherwise no grant.
- Lock:
  - Set on a cmd accept with cmd_last=0.
  - Cleared on a cmd accept with cmd_last=1.
  - Holds across idle cycles while cmd_valid is low.
  - cmd_locked = lock.
- Burst counter:
  - Increments on each pix accept, saturating at MAX_PIX_BURST.
  - Clears to 0 on any cmd accept.
  - Width is clog2(MAX_PIX_BURST+1).
- Simultaneous events:
  - pix_valid and cmd_valid both high, burst<MAX, unlocked: pixel wins.
  - At burst=MAX: cmd wins once, counter clears, pixels resume.
- Inputs are sampled only at the accept edge; changes during LOW/HIGH are ignored.
- Reset mid-transfer: WR returns high asynchronously and the in-flight word is abandoned. It counts as already accepted; the requester does not resend. Lock is lost, so a command producer must restart its transaction after reset.
- No pin reset or power-up delays here; those stay in the command producer.

Test Plan:
- Reset, then pix_valid=1 continuously with data 0x0001, 0x0002, … -> WR toggles 0/1 every clock starting the cycle after the first accept. screenData follows the sequence, screenRS=1, cmd_ready never high.
- cmd_valid with words {rs0 0x2A, last0}, {rs1 0x00, last0}, {rs1 0xEF, last1} while pix_valid=1 and burst<MAX -> the 3 cmd words appear back-to-back once a cmd word is granted. No pixel word is interleaved. cmd_locked is high from the first to the last accept.
- MAX_PIX_BURST=4, pix_valid and cmd_valid both held high -> grant pattern pix×4, cmd, pix×4, cmd. Burst count reads 0 after each cmd accept.
- WR_LOW_CYCLES=3, WR_HIGH_CYCLES=2, single pix word 0xF800 -> WR low exactly 3 cycles, then high. The next accept comes no earlier than 5 cycles after the previous one. screenData is stable throughout.
- Assert rst during LOW of a locked cmd transaction -> screenWR=1 in the same cycle (asynchronous), screenData=0, screenRS=1, cmd_locked=0. After release, pixels are granted immediately when pix_valid=1.
- Lock held with cmd_valid low for 10 cycles, pix_valid=1 -> no pixel accepted, busy=0, WR stays high. Resumes when the cmd with last=1 is accepted.

Source files
------------

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter: shares the 16-bit TFT write bus between a pixel stream and a command port,
// generating WR strobes and keeping multi-word commands atomic with bounded pixel priority.
module tft_bus_arbiter #(
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1,
    parameter int MAX_PIX_BURST  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic        pix_rs,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        cmd_valid,
    input  logic        cmd_rs,
    input  logic [15:0] cmd_data,
    input  logic        cmd_last,
    output logic        cmd_ready,
    output logic        screenRD,
    output logic        screenWR,
    output logic        screenRS,
    output logic [15:0] screenData,
    output logic        busy,
    output logic        cmd_locked
);
    localparam int BW = $clog2(MAX_PIX_BURST + 1);
    localparam int CW = $clog2(WR_LOW_CYCLES + WR_HIGH_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] burst_q, burst_d;
    logic          lock_q, lock_d;
    logic          wr_q, rs_q;
    logic [15:0]   data_q;
    logic          idle, burst_full;
    always_comb begin
        idle       = state_q == IDLE;
        burst_full = burst_q >= BW'(MAX_PIX_BURST);
        // a held lock gives the command port exclusive access, even while it is idle
        cmd_ready  = idle && cmd_valid && (lock_q || !pix_valid || burst_full);
        pix_ready  = idle && pix_valid && !lock_q && !cmd_ready;
        lock_d     = cmd_ready ? !cmd_last : lock_q;
        burst_d    = cmd_ready ? '0 : (pix_ready && !burst_full) ? burst_q + 1'b1 : burst_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            burst_q <= '0;
            lock_q  <= 1'b0;
            wr_q    <= 1'b1;
            rs_q    <= 1'b1;
            data_q  <= '0;
        end else begin
            lock_q  <= lock_d;
            burst_q <= burst_d;
            case (state_q)
                IDLE: if (cmd_ready || pix_ready) begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                    wr_q    <= 1'b0;
                    rs_q    <= cmd_ready ? cmd_rs : pix_rs;
                    data_q  <= cmd_ready ? cmd_data : pix_data;
                end
                LOW: if (cnt_q == CW'(WR_LOW_CYCLES - 1)) begin
                    wr_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= (WR_HIGH_CYCLES > 1) ? HIGH : IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                HIGH: if (cnt_q == CW'(WR_HIGH_CYCLES - 2)) state_q <= IDLE;
                      else cnt_q <= cnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign screenRD   = 1'b1;
    assign screenWR   = wr_q;
    assign screenRS   = rs_q;
    assign screenData = data_q;
    assign busy       = !idle;
    assign cmd_locked = lock_q;
endmodule
